parity_frame_ctrl: RTL



---
 rtl/parity_frame_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - word-to-serial framer with trailing running-parity bit
//
// Accepts a DATA_W-bit word on in_valid/in_ready, shifts it out LSB-first on
// ser_out (one bit per clock, ser_valid high), then sends the parity bit with
// ser_last high, pulses frame_done for one cycle, idles GAP_CYC cycles, and
// returns to IDLE. Every output is decoded from registered state only.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    parallel word, captured on the accepting edge
//   in_valid   producer has a word
//   in_ready   high only in IDLE
//   ser_out    serial bit (data LSB-first, then parity)
//   ser_valid  high on data and parity cycles
//   ser_last   high on the parity cycle only
//   busy       high in any state other than IDLE
//   frame_done one-cycle pulse after the parity cycle
//
// Build option: ODD_PARITY_EN selects odd parity (default is even parity).

module parity_frame_ctrl #(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_DONE,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [3:0]        gap_cnt;
    logic              acc;
    logic              par_bit;

`ifdef ODD_PARITY_EN
    assign par_bit = ~acc;
`else
    assign par_bit = acc;
`endif

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                ser_out   = shreg[0];
                ser_valid = 1'b1;
                if (bit_cnt == LAST_BIT) state_nx = S_PARITY;
            end
            S_PARITY: begin
                ser_out   = par_bit;
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                state_nx  = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = (GAP_CYC > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            acc     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        acc     <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    // acc ends as XOR of every bit that left shreg[0]
                    acc     <= acc ^ shreg[0];
                    shreg   <= {1'b0, shreg[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_DONE: begin
                    gap_cnt <= '0;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
